// File: rtl/store_commit_unit.sv
// Store commit unit: drains retired stores from the STQ head to memory in program order.
// Optional WAIT-state watchdog is built when STQ_COMMIT_TIMEOUT_EN is defined.
module store_commit_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned STQ_SIZE       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [STQ_SIZE-1:0]                 stq_valid,
  input  logic [STQ_SIZE-1:0]                 stq_retired,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]       stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]       stq_data,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [XLEN-1:0]                     mem_req_addr,
  output logic [XLEN-1:0]                     mem_req_data,
  input  logic                                mem_resp_valid,
  output logic [$clog2(STQ_SIZE)-1:0]         stq_head,
  output logic                                stq_commit,
  output logic [$clog2(STQ_SIZE)-1:0]         stq_commit_index,
  output logic                                busy,
  output logic                                timeout_error
);

  localparam int unsigned IW = $clog2(STQ_SIZE);

  if (STQ_SIZE < 2 || (STQ_SIZE & (STQ_SIZE - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("store_commit_unit: STQ_SIZE must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     head_n;
  logic              req_valid_n;
  logic [XLEN-1:0]   addr_n;
  logic [XLEN-1:0]   data_n;
  logic              commit_n;
  logic [IW-1:0]     commit_index_n;

  // Every output is a register; this block only computes their next values.
  always_comb begin
    state_n        = state;
    head_n         = stq_head;
    req_valid_n    = mem_req_valid;
    addr_n         = mem_req_addr;
    data_n         = mem_req_data;
    commit_n       = 1'b0;
    commit_index_n = stq_commit_index;
    case (state)
      S_IDLE: begin
        if (stq_valid[stq_head] && stq_retired[stq_head]) begin
          state_n     = S_REQ;
          req_valid_n = 1'b1;
          addr_n      = stq_address[stq_head];
          data_n      = stq_data[stq_head];
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_n     = S_WAIT;
          req_valid_n = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_n        = S_COMMIT;
          commit_n       = 1'b1;
          commit_index_n = stq_head;
        end
      end
      S_COMMIT: begin
        // Head advances only on the exit edge so age compares stay valid during the pulse.
        head_n  = stq_head + 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n     = S_IDLE;
        req_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      stq_head         <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_data     <= '0;
      stq_commit       <= 1'b0;
      stq_commit_index <= '0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      stq_head         <= head_n;
      mem_req_valid    <= req_valid_n;
      mem_req_addr     <= addr_n;
      mem_req_data     <= data_n;
      stq_commit       <= commit_n;
      stq_commit_index <= commit_index_n;
      busy             <= (state_n != S_IDLE);
    end
  end

`ifdef STQ_COMMIT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          timeout_n;

  // Counter saturates at the limit; the flag is raised on the edge the count reaches it.
  always_comb begin
    wait_cnt_n = wait_cnt;
    timeout_n  = timeout_error;
    if (state == S_REQ && mem_req_ready) begin
      wait_cnt_n = '0;
    end else if (state == S_WAIT && !mem_resp_valid && wait_cnt != TLIM) begin
      wait_cnt_n = wait_cnt + 1'b1;
      if (wait_cnt_n == TLIM) begin
        timeout_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_n;
      timeout_error <= timeout_n;
    end
  end
`else
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed self-checking bench for store_commit_unit (STQ_SIZE=32, TIMEOUT_CYCLES=8).
module tb_store_commit_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STQ_SIZE = 32;

  logic                          clk;
  logic                          reset_n;
  logic [STQ_SIZE-1:0]           stq_valid;
  logic [STQ_SIZE-1:0]           stq_retired;
  logic [STQ_SIZE-1:0][XLEN-1:0] stq_address;
  logic [STQ_SIZE-1:0][XLEN-1:0] stq_data;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [XLEN-1:0]               mem_req_addr;
  logic [XLEN-1:0]               mem_req_data;
  logic                          mem_resp_valid;
  logic [4:0]                    stq_head;
  logic                          stq_commit;
  logic [4:0]                    stq_commit_index;
  logic                          busy;
  logic                          timeout_error;

  int vectors = 0;
  int miscompares = 0;

  store_commit_unit #(
    .XLEN(XLEN),
    .STQ_SIZE(STQ_SIZE),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stq_valid(stq_valid),
    .stq_retired(stq_retired),
    .stq_address(stq_address),
    .stq_data(stq_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid),
    .stq_head(stq_head),
    .stq_commit(stq_commit),
    .stq_commit_index(stq_commit_index),
    .busy(busy),
    .timeout_error(timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stq_valid = '0;
    stq_retired = '0;
    stq_address = '0;
    stq_data = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got=%0b exp=0", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", mem_req_addr); end
    vectors++; if (mem_req_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", mem_req_data); end
    vectors++; if (stq_head !== 5'd0) begin miscompares++; $display("FAIL reset_head got=%0d exp=0", stq_head); end
    vectors++; if (stq_commit !== 1'b0 || stq_commit_index !== 5'd0) begin miscompares++; $display("FAIL reset_commit got=%0b/%0d exp=0/0", stq_commit, stq_commit_index); end
    vectors++; if (busy !== 1'b0 || timeout_error !== 1'b0) begin miscompares++; $display("FAIL reset_busy_to got=%0b/%0b exp=0/0", busy, timeout_error); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    vectors++; if (busy !== 1'b0 || stq_head !== 5'd0) begin miscompares++; $display("FAIL reset_release got busy=%0b head=%0d exp=0/0", busy, stq_head); end
  endtask

  // Drives one store at the given entry through to commit with ready=1 and an ack
  // one cycle after the handshake, acting as allocator (clears the entry on commit).
  task automatic commit_one(input logic [4:0] idx, input logic [31:0] a, input logic [31:0] d);
    logic hs;
    logic done;
    logic [4:0] nxt;
    stq_address[idx] = a;
    stq_data[idx] = d;
    stq_valid[idx] = 1'b1;
    stq_retired[idx] = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = mem_req_valid && mem_req_ready;
      if (mem_req_valid) begin
        vectors++; if (mem_req_addr !== a || mem_req_data !== d) begin miscompares++; $display("FAIL c1_req_payload idx=%0d got=%h/%h exp=%h/%h", idx, mem_req_addr, mem_req_data, a, d); end
      end
      cyc();
      mem_resp_valid = hs;
      if (stq_commit) begin
        vectors++; if (stq_commit_index !== idx || stq_head !== idx) begin miscompares++; $display("FAIL c1_commit got idx=%0d head=%0d exp=%0d", stq_commit_index, stq_head, idx); end
        stq_valid[idx] = 1'b0;
        stq_retired[idx] = 1'b0;
        done = 1'b1;
      end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL c1_timeout idx=%0d got no commit exp commit within 20 cycles", idx); end
    mem_resp_valid = 1'b0;
    cyc();
    nxt = idx + 5'd1;
    vectors++; if (stq_head !== nxt || stq_commit !== 1'b0) begin miscompares++; $display("FAIL c1_head_adv got head=%0d commit=%0b exp=%0d/0", stq_head, stq_commit, nxt); end
  endtask

  task automatic test_basic_commit();
    stq_address[0] = 32'h0000_1000;
    stq_data[0] = 32'hDEAD_BEEF;
    stq_valid[0] = 1'b1;
    stq_retired[0] = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    cyc();
    vectors++; if (mem_req_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_req got valid=%0b busy=%0b exp=1/1", mem_req_valid, busy); end
    vectors++; if (mem_req_addr !== 32'h0000_1000 || mem_req_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL basic_payload got=%h/%h exp=00001000/deadbeef", mem_req_addr, mem_req_data); end
    cyc();
    vectors++; if (mem_req_valid !== 1'b0 || stq_commit !== 1'b0) begin miscompares++; $display("FAIL basic_after_hs got valid=%0b commit=%0b exp=0/0", mem_req_valid, stq_commit); end
    mem_resp_valid = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    vectors++; if (stq_commit !== 1'b1 || stq_commit_index !== 5'd0 || stq_head !== 5'd0) begin miscompares++; $display("FAIL basic_commit got c=%0b idx=%0d head=%0d exp=1/0/0", stq_commit, stq_commit_index, stq_head); end
    stq_valid[0] = 1'b0;
    stq_retired[0] = 1'b0;
    cyc();
    vectors++; if (stq_commit !== 1'b0 || stq_head !== 5'd1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_exit got c=%0b head=%0d busy=%0b exp=0/1/0", stq_commit, stq_head, busy); end
  endtask

  task automatic test_backpressure();
    stq_address[1] = 32'h0000_2004;
    stq_data[1] = 32'h1234_5678;
    stq_valid[1] = 1'b1;
    stq_retired[1] = 1'b1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_2004 || mem_req_data !== 32'h1234_5678) begin miscompares++; $display("FAIL bp_hold cyc=%0d got v=%0b %h/%h exp=1 00002004/12345678", i, mem_req_valid, mem_req_addr, mem_req_data); end
      vectors++; if (stq_commit !== 1'b0) begin miscompares++; $display("FAIL bp_no_commit cyc=%0d got=%0b exp=0", i, stq_commit); end
      cyc();
    end
    mem_req_ready = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0 || stq_commit !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_hs_ack_ignored got v=%0b c=%0b busy=%0b exp=0/0/1", mem_req_valid, stq_commit, busy); end
    cyc();
    vectors++; if (stq_commit !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_wait got c=%0b busy=%0b exp=0/1", stq_commit, busy); end
    mem_resp_valid = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    vectors++; if (stq_commit !== 1'b1 || stq_commit_index !== 5'd1) begin miscompares++; $display("FAIL bp_commit got c=%0b idx=%0d exp=1/1", stq_commit, stq_commit_index); end
    stq_valid[1] = 1'b0;
    stq_retired[1] = 1'b0;
    cyc();
    vectors++; if (stq_head !== 5'd2) begin miscompares++; $display("FAIL bp_head got=%0d exp=2", stq_head); end
  endtask

  task automatic test_back_to_back();
    logic hs;
    int n;
    int outstanding;
    int last;
    commit_one(5'd2, 32'h0000_3000, 32'hA5A5_0002);
    for (int e = 3; e <= 5; e++) begin
      stq_address[e] = 32'h0000_4000 + 32'(e * 4);
      stq_data[e] = 32'hB0B0_0000 + 32'(e);
      stq_valid[e] = 1'b1;
      stq_retired[e] = 1'b1;
    end
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    n = 0;
    outstanding = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      hs = mem_req_valid && mem_req_ready;
      if (mem_req_valid) begin
        vectors++; if (outstanding != 0) begin miscompares++; $display("FAIL b2b_overlap got outstanding=%0d exp=0 while requesting", outstanding); end
      end
      cyc();
      mem_resp_valid = hs;
      if (hs) outstanding++;
      if (stq_commit) begin
        vectors++; if (stq_commit_index !== 5'(3 + n)) begin miscompares++; $display("FAIL b2b_order got=%0d exp=%0d", stq_commit_index, 3 + n); end
        if (n > 0) begin
          vectors++; if (c - last < 4) begin miscompares++; $display("FAIL b2b_gap got=%0d exp>=4", c - last); end
        end
        last = c;
        stq_valid[stq_commit_index] = 1'b0;
        stq_retired[stq_commit_index] = 1'b0;
        outstanding--;
        n++;
      end
    end
    vectors++; if (n != 3) begin miscompares++; $display("FAIL b2b_count got=%0d exp=3", n); end
    mem_resp_valid = 1'b0;
    cyc();
    vectors++; if (stq_head !== 5'd6) begin miscompares++; $display("FAIL b2b_head got=%0d exp=6", stq_head); end
  endtask

  task automatic test_wrap_and_block();
    for (int e = 6; e <= 30; e++) commit_one(5'(e), 32'h0001_0000 + 32'(e), 32'hC0DE_0000 + 32'(e));
    vectors++; if (stq_head !== 5'd31) begin miscompares++; $display("FAIL wrap_pre_head got=%0d exp=31", stq_head); end
    commit_one(5'd31, 32'h0000_7FFC, 32'h3131_3131);
    vectors++; if (stq_head !== 5'd0) begin miscompares++; $display("FAIL wrap_head got=%0d exp=0", stq_head); end
    stq_address[0] = 32'h0000_8000;
    stq_data[0] = 32'h0BAD_F00D;
    stq_valid[0] = 1'b1;
    stq_retired[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      vectors++; if (mem_req_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL block_no_req cyc=%0d got v=%0b busy=%0b exp=0/0", i, mem_req_valid, busy); end
    end
    stq_retired[0] = 1'b1;
    cyc();
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_8000) begin miscompares++; $display("FAIL block_release got v=%0b addr=%h exp=1/00008000", mem_req_valid, mem_req_addr); end
    commit_one(5'd0, 32'h0000_8000, 32'h0BAD_F00D);
  endtask

  task automatic test_reset_mid_wait();
    stq_address[1] = 32'h0000_9000;
    stq_data[1] = 32'h5555_AAAA;
    stq_valid[1] = 1'b1;
    stq_retired[1] = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    cyc();
    cyc();
    vectors++; if (busy !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0000_9000) begin miscompares++; $display("FAIL rst_pre_wait got busy=%0b v=%0b addr=%h exp=1/0/00009000", busy, mem_req_valid, mem_req_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || stq_head !== 5'd0 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async got busy=%0b head=%0d v=%0b exp=0/0/0", busy, stq_head, mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h0 || mem_req_data !== 32'h0 || stq_commit !== 1'b0) begin miscompares++; $display("FAIL rst_async_data got %h/%h c=%0b exp=0/0/0", mem_req_addr, mem_req_data, stq_commit); end
    stq_valid = '0;
    stq_retired = '0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    vectors++; if (busy !== 1'b0 || stq_head !== 5'd0 || timeout_error !== 1'b0) begin miscompares++; $display("FAIL rst_release got busy=%0b head=%0d to=%0b exp=0/0/0", busy, stq_head, timeout_error); end
  endtask

  task automatic test_watchdog();
    logic exp_to;
    stq_address[0] = 32'h0000_A000;
    stq_data[0] = 32'h7777_0000;
    stq_valid[0] = 1'b1;
    stq_retired[0] = 1'b1;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    cyc();
    cyc();
    for (int k = 1; k <= 13; k++) begin
      cyc();
`ifdef STQ_COMMIT_TIMEOUT_EN
      exp_to = (k >= 8);
`else
      exp_to = 1'b0;
`endif
      vectors++; if (timeout_error !== exp_to || busy !== 1'b1 || stq_commit !== 1'b0) begin miscompares++; $display("FAIL wd_wait k=%0d got to=%0b busy=%0b c=%0b exp=%0b/1/0", k, timeout_error, busy, stq_commit, exp_to); end
    end
    mem_resp_valid = 1'b1;
    cyc();
    mem_resp_valid = 1'b0;
    vectors++; if (stq_commit !== 1'b1 || stq_commit_index !== 5'd0) begin miscompares++; $display("FAIL wd_late_ack got c=%0b idx=%0d exp=1/0", stq_commit, stq_commit_index); end
    stq_valid[0] = 1'b0;
    stq_retired[0] = 1'b0;
    cyc();
`ifdef STQ_COMMIT_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    vectors++; if (timeout_error !== exp_to || stq_head !== 5'd1 || busy !== 1'b0) begin miscompares++; $display("FAIL wd_sticky got to=%0b head=%0d busy=%0b exp=%0b/1/0", timeout_error, stq_head, busy, exp_to); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_backpressure();
    test_back_to_back();
    test_wrap_and_block();
    test_reset_mid_wait();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule
